// File: rtl/fpu_div_seq.sv
// Iterative binary32 divider: one-cycle special cases, restoring division (one quotient bit
// per cycle), round-to-nearest-even, RISC-V fflags, valid/ready on both sides.
module fpu_div_seq #(
   parameter logic [31:0] CANON_NAN    = 32'h7FC00000,
   parameter bit          SPECIAL_FAST = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic [4:0]  out_flags
);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_SPEC, S_DIV, S_ROUND, S_DONE} state_t;
   typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_SNAN, C_QNAN} cls_t;
   typedef struct packed {
      cls_t              cls;
      logic signed [9:0] exp;
      logic [23:0]       sig;
   } op_t;

   localparam logic [4:0] F_NV = 5'b10000;
   localparam logic [4:0] F_DZ = 5'b01000;
   localparam logic [4:0] F_OF = 5'b00100;
   localparam logic [4:0] F_UF = 5'b00010;
   localparam logic [4:0] F_NX = 5'b00001;

   function automatic op_t decode(input logic [31:0] x);
      op_t        d;
      logic [4:0] shift;
      d.cls = C_NORM;
      d.exp = $signed({2'b00, x[30:23]}) - 10'sd127;
      d.sig = {1'b1, x[22:0]};
      shift = 5'd0;
      if (x[30:23] == 8'hFF) begin
         d.cls = (x[22:0] == 23'd0) ? C_INF : (x[22] ? C_QNAN : C_SNAN);
      end else if (x[30:23] == 8'd0) begin
         if (x[22:0] == 23'd0) begin
            d.cls = C_ZERO;
            d.exp = 10'sd0;
            d.sig = 24'd0;
         end else begin
            // Highest set fraction bit wins; normalise it up to bit 23.
            for (int i = 0; i < 23; i++)
               if (x[i]) shift = 5'(23 - i);
            d.cls = C_SUB;
            d.sig = {1'b0, x[22:0]} << shift;
            d.exp = -10'sd126 - $signed({5'b00000, shift});
         end
      end
      return d;
   endfunction

   state_t            r_state, w_next;
   logic [31:0]       r_a, r_b;
   logic [4:0]        r_cnt;
   logic [24:0]       r_rem;
   logic [25:0]       r_q;
   logic [23:0]       r_sig_b;
   logic signed [9:0] r_exp;
   logic              r_sign;
   logic [31:0]       r_res;
   logic [4:0]        r_flags;

   op_t               w_op_a, w_op_b;
   logic              w_sign, w_a_nan, w_b_nan, w_special;
   logic [31:0]       w_spec_res;
   logic [4:0]        w_spec_flags;
   logic              w_lt;
   logic signed [9:0] w_exp_init;
   logic [24:0]       w_dividend;
   logic [24:0]       w_rem_sh, w_rem_next;
   logic              w_qbit;
   logic              w_sticky, w_inc, w_nx;
   logic [24:0]       w_mant;
   logic [22:0]       w_frac;
   logic signed [9:0] w_exp_rnd;
   logic [31:0]       w_rnd_res;
   logic [4:0]        w_rnd_flags;

   assign w_op_a  = decode(r_a);
   assign w_op_b  = decode(r_b);
   assign w_sign  = r_a[31] ^ r_b[31];
   assign w_a_nan = (w_op_a.cls == C_SNAN) || (w_op_a.cls == C_QNAN);
   assign w_b_nan = (w_op_b.cls == C_SNAN) || (w_op_b.cls == C_QNAN);

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      w_special    = 1'b1;
      w_spec_res   = 32'd0;
      w_spec_flags = 5'd0;
      if (w_a_nan || w_b_nan) begin
         w_spec_res   = CANON_NAN;
         w_spec_flags = ((w_op_a.cls == C_SNAN) || (w_op_b.cls == C_SNAN)) ? F_NV : 5'd0;
      end else if ((w_op_a.cls == C_ZERO && w_op_b.cls == C_ZERO) ||
                   (w_op_a.cls == C_INF  && w_op_b.cls == C_INF)) begin
         w_spec_res   = CANON_NAN;
         w_spec_flags = F_NV;
      end else if (w_op_b.cls == C_ZERO && w_op_a.cls != C_INF) begin
         w_spec_res   = {w_sign, 8'hFF, 23'd0};
         w_spec_flags = F_DZ;
      end else if (w_op_a.cls == C_INF) begin
         w_spec_res   = {w_sign, 8'hFF, 23'd0};
      end else if (w_op_a.cls == C_ZERO || w_op_b.cls == C_INF) begin
         w_spec_res   = {w_sign, 31'd0};
      end else begin
         w_special    = 1'b0;
      end
   end

   // Pre-scale so the first quotient bit is always the leading 1.
   assign w_lt       = w_op_a.sig < w_op_b.sig;
   assign w_exp_init = w_op_a.exp - w_op_b.exp + 10'sd127 - (w_lt ? 10'sd1 : 10'sd0);
   assign w_dividend = w_lt ? {w_op_a.sig, 1'b0} : {1'b0, w_op_a.sig};

   assign w_rem_sh   = (r_cnt == 5'd0) ? r_rem : {r_rem[23:0], 1'b0};
   assign w_qbit     = w_rem_sh >= {1'b0, r_sig_b};
   assign w_rem_next = w_qbit ? (w_rem_sh - {1'b0, r_sig_b}) : w_rem_sh;

   assign w_sticky   = |r_rem;
   assign w_inc      = r_q[1] & (r_q[2] | r_q[0] | w_sticky);
   assign w_nx       = r_q[1] | r_q[0] | w_sticky;
   assign w_mant     = {1'b0, r_q[25:2]} + {24'd0, w_inc};
   // A carry to 2.0 clears bit 23 and leaves an all-zero fraction.
   assign w_frac     = w_mant[23] ? w_mant[22:0] : 23'd0;
   assign w_exp_rnd  = r_exp + $signed({9'd0, w_mant[24]});

   always_comb begin
      w_rnd_res   = {r_sign, w_exp_rnd[7:0], w_frac};
      w_rnd_flags = w_nx ? F_NX : 5'd0;
      if (w_exp_rnd >= 10'sd255) begin
         w_rnd_res   = {r_sign, 8'hFF, 23'd0};
         w_rnd_flags = F_OF | F_NX;
      end else if (w_exp_rnd <= 10'sd0) begin
         w_rnd_res   = {r_sign, 31'd0};
         w_rnd_flags = F_UF | F_NX;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (in_valid && !flush) w_next = S_DECODE;
         S_DECODE: w_next = w_special ? (SPECIAL_FAST ? S_DONE : S_SPEC) : S_DIV;
         S_SPEC:   if (r_cnt == 5'd26) w_next = S_DONE;
         S_DIV:    if (r_cnt == 5'd25) w_next = S_ROUND;
         S_ROUND:  w_next = S_DONE;
         S_DONE:   if (out_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (flush && r_state != S_IDLE) w_next = S_IDLE;
   end

   always_comb begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_DONE);
   end

   assign out_res   = r_res;
   assign out_flags = r_flags;

   // NOTE: only the visible result is reset; the datapath is always loaded before it is read.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_res   <= 32'd0;
         r_flags <= 5'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_a <= in_a;
               r_b <= in_b;
            end
            S_DECODE: begin
               r_cnt   <= 5'd0;
               r_rem   <= w_dividend;
               r_q     <= 26'd0;
               r_sig_b <= w_op_b.sig;
               r_exp   <= w_exp_init;
               r_sign  <= w_sign;
               if (w_special) begin
                  r_res   <= w_spec_res;
                  r_flags <= w_spec_flags;
               end
            end
            S_SPEC: r_cnt <= r_cnt + 5'd1;
            S_DIV: begin
               r_rem <= w_rem_next;
               r_q   <= {r_q[24:0], w_qbit};
               r_cnt <= r_cnt + 5'd1;
            end
            S_ROUND: begin
               r_res   <= w_rnd_res;
               r_flags <= w_rnd_flags;
            end
            default: ;
         endcase
      end
   end

endmodule
